// File: rtl/regfile_core.sv
// regfile_core: 2^ADDR_W x DATA_W register file, one write port, two read ports, r0 hardwired to 0.
// Latency: writes commit on the rising edge of clk; both read ports are purely combinational.
// Backpressure: none; a write is taken on every edge where ctrl_writeEnable is high.
// Optional: define REGFILE_BYPASS_EN to forward in-flight write data to the read ports.
module regfile_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB
);
    localparam int NREG = 1 << ADDR_W;

    // Register 0 has no storage at all, so the arrays start at index 1.
    logic [DATA_W-1:0] regs_q [1:NREG-1];
    logic [DATA_W-1:0] regs_d [1:NREG-1];
    logic [NREG-1:1]   cell_en;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // One-hot write decode; a write addressed to index 0 matches no cell and is dropped.
    always_comb begin
        cell_en = '0;
        for (int i = 1; i < NREG; i++) begin
            cell_en[i] = ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(i));
        end
    end

    // Next state per cell: enabled cells load the write data, all others hold.
    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            regs_d[i] = cell_en[i] ? data_writeReg : regs_q[i];
        end
    end

    // Storage cells; clr clears asynchronously and wins over a coincident write edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read muxes; index 0 never matches a stored register and falls through to zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 1; i < NREG; i++) begin
            if (ctrl_readRegA == ADDR_W'(i)) begin
                rd_a = regs_q[i];
            end
            if (ctrl_readRegB == ADDR_W'(i)) begin
                rd_b = regs_q[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_ok;

    // Write-through: a port addressing the register being written sees the new data before the edge.
    always_comb begin
        fwd_ok        = !clr && ctrl_writeEnable && (ctrl_writeReg != '0);
        data_readRegA = (fwd_ok && (ctrl_readRegA == ctrl_writeReg)) ? data_writeReg : rd_a;
        data_readRegB = (fwd_ok && (ctrl_readRegB == ctrl_writeReg)) ? data_writeReg : rd_b;
    end
`else
    // Reads reflect committed storage only.
    always_comb begin
        data_readRegA = rd_a;
        data_readRegB = rd_b;
    end
`endif

endmodule

// File: tb/tb_regfile_core.sv
// tb_regfile_core: scoreboard bench for regfile_core against an array reference model.
// Stimulus pushes expected read values into a queue and raises obs_vld mid-cycle;
// the monitor pops on each obs_vld pulse and compares both read ports.
`timescale 1ns/1ps
module tb_regfile_core;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [DATA_W-1:0] ea;
        logic [DATA_W-1:0] eb;
    } exp_t;

    logic              clk = 1'b0;
    logic              clr;
    logic              we;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    logic [DATA_W-1:0] model [NREG];
    exp_t              exp_q [$];
    string             tag_q [$];
    logic              obs_vld = 1'b0;
    int                checks  = 0;
    int                passes  = 0;
    exp_t              mon_e;
    string             mon_t;

    initial forever #100 clk = ~clk;

    regfile_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .clr              (clr),
        .ctrl_writeEnable (we),
        .ctrl_writeReg    (wr),
        .data_writeReg    (wd),
        .ctrl_readRegA    (ra),
        .ctrl_readRegB    (rb),
        .data_readRegA    (rd_a),
        .data_readRegB    (rd_b)
    );

    // Expected read value straight from the rules: clear reads 0, r0 reads 0,
    // forwarding (when built in) shows the pending write, else committed contents.
    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] idx);
        if (clr) return '0;
        if (idx == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && (wr != '0) && (idx == wr)) return wd;
`endif
        return model[idx];
    endfunction

    task automatic clear_model();
        foreach (model[i]) model[i] = '0;
    endtask

    // Let inputs settle, queue the expectation, then pulse obs_vld for the monitor.
    task automatic sample(input string tag);
        exp_t e;
        #1;
        e.ra = ra;
        e.rb = rb;
        e.ea = ref_read(ra);
        e.eb = ref_read(rb);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        obs_vld = 1'b1;
        #1;
        obs_vld = 1'b0;
    endtask

    // One clock cycle: drive at posedge+1, optionally check, then commit the model at the edge.
    task automatic cycle(input logic w_en, input logic [ADDR_W-1:0] w_idx,
                         input logic [DATA_W-1:0] w_dat, input logic [ADDR_W-1:0] a_idx,
                         input logic [ADDR_W-1:0] b_idx, input string tag);
        we = w_en;
        wr = w_idx;
        wd = w_dat;
        ra = a_idx;
        rb = b_idx;
        if (tag != "") sample(tag);
        @(posedge clk);
        if (!clr && we && (wr != '0)) model[wr] = wd;
        #1;
    endtask

    // Check every index within a single cycle (no clock edge crossed).
    task automatic sweep(input string tag);
        for (int i = 0; i < NREG / 2; i++) begin
            ra = ADDR_W'(i);
            rb = ADDR_W'(i + NREG / 2);
            sample(tag);
        end
    endtask

    // Monitor: pop one expectation per observation and compare both ports.
    always @(posedge obs_vld) begin
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL scoreboard_underflow: observation with no expectation queued");
        end else begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            checks++;
            if (rd_a === mon_e.ea) passes++;
            else $display("FAIL %s portA idx=%0d got=%h expected=%h", mon_t, mon_e.ra, rd_a, mon_e.ea);
            checks++;
            if (rd_b === mon_e.eb) passes++;
            else $display("FAIL %s portB idx=%0d got=%h expected=%h", mon_t, mon_e.rb, rd_b, mon_e.eb);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [ADDR_W-1:0] r_wr;
        clear_model();
        clr = 1'b1; we = 1'b0; wr = '0; wd = '0; ra = '0; rb = '0;
        #20;
        ra = 5'd0; rb = 5'd5;
        sample("reset_hold");
        @(posedge clk); #1;
        clr = 1'b0;
        ra = 5'd31; rb = 5'd1;
        sample("reset_released");

        // Basic write/read
        cycle(1'b1, 5'd5,  32'hDEADBEEF, 5'd0, 5'd0, "");
        cycle(1'b1, 5'd31, 32'h12345678, 5'd0, 5'd0, "");
        cycle(1'b0, 5'd0,  32'h0,        5'd5, 5'd31, "read_5_31");
        cycle(1'b0, 5'd0,  32'h0,        5'd5, 5'd5,  "read_5_5");

        // Register 0 drops writes; the rest stay intact
        cycle(1'b1, 5'd7, 32'h00000011, 5'd0, 5'd0, "");
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "r0_write");
        we = 1'b0;
        sweep("r0_sweep");

        // Enable low: r7 must not change
        for (int k = 0; k < 3; k++) cycle(1'b0, 5'd7, 32'hAAAAAAAA, 5'd7, 5'd0, "enable_low");
        cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "enable_low_after");

        // Clear vs write race on r9
        cycle(1'b1, 5'd9, 32'h55555555, 5'd9, 5'd0, "race_pre");
        clr = 1'b1;
        clear_model();
        cycle(1'b1, 5'd9, 32'h0F0F0F0F, 5'd9, 5'd0, "race_clr_edge");
        sample("race_after_edge");
        clr = 1'b0;
        cycle(1'b1, 5'd9, 32'h0F0F0F0F, 5'd9, 5'd0, "race_released");
        cycle(1'b0, 5'd0, 32'h0,        5'd9, 5'd9, "race_written");

        // Same-cycle read/write on r3 (old 1, new 2), and r0 never forwarded
        cycle(1'b1, 5'd3, 32'h1, 5'd0, 5'd0, "");
        cycle(1'b1, 5'd3, 32'h2, 5'd3, 5'd0, "r3_same_cycle");
        cycle(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "r3_after_edge");
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd3, 5'd0, "r0_no_forward");

        // Randomized traffic, biased so reads often hit the write index
        for (int n = 0; n < 300; n++) begin
            r_wr = ADDR_W'($urandom);
            cycle(1'($urandom), r_wr, DATA_W'($urandom),
                  ($urandom_range(0, 2) == 0) ? r_wr : ADDR_W'($urandom),
                  ($urandom_range(0, 2) == 0) ? r_wr : ADDR_W'($urandom),
                  ($urandom_range(0, 3) == 0) ? "" : "random");
        end

        // Mid-cycle clear with live data: every index reads 0 with no clock edge
        cycle(1'b1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd0, "");
        we = 1'b0;
        sample("pre_midcycle_clr");
        clr = 1'b1;
        clear_model();
        sweep("midcycle_clr");
        @(posedge clk); #1;
        clr = 1'b0;
        cycle(1'b1, 5'd12, 32'h600DD00D, 5'd0, 5'd0, "");
        cycle(1'b0, 5'd0,  32'h0,        5'd12, 5'd13, "after_clr_write");
        sweep("final_sweep");

        #10;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
